fft_butterfly_r2: RTL and testbench

Pipelined radix-2 decimation-in-time butterfly for the 256-point FFT datapath, directly downstream of `fft_twiddle_rom`. For each accepted sample pair it issues the twiddle address to the ROM and consumes the 1-cycle-latency twiddle word. It computes X = A + W·B and Y = A − W·B with rounding, optional per-stage ½ scaling, and saturation. The output uses a valid/ready handshake with full backpressure.

---
 rtl/fft_params_pkg.sv | 30 +++
 rtl/fft_cmul.sv | 64 ++++++
 rtl/fft_butterfly_r2.sv | 149 ++++++++++++++
 tb/tb_fft_butterfly_r2.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_params_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_params_pkg
// Description : Shared FFT datapath types, widths and saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_params_pkg;

    localparam int COEFF_WIDTH = 16;
    localparam int COEFF_FRAC  = 14;
    localparam int DATA_W      = 16;
    localparam int DATA_FRAC   = 15;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx16_t;

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767) begin
            return 16'sh7fff;
        end else if (v < -33'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_cmul.sv
`default_nettype none
// ============================================================================
// Module      : fft_cmul
// Description : Two-stage pipelined complex multiply W*B with round-half-up
//               and saturation to 16-bit components.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_cmul
    import fft_params_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TW_W    = COEFF_WIDTH,
    parameter int TW_FRAC = COEFF_FRAC
)(
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [2*DATA_W-1:0]   b_i,
    input  logic [2*TW_W-1:0]     w_i,
    output logic [2*DATA_W-1:0]   wb_o
);

    localparam int PW = DATA_W + TW_W;
    localparam logic signed [PW:0] c_RND = (PW+1)'(1) <<< (TW_FRAC - 1);

    logic signed [DATA_W-1:0] w_br, w_bi;
    logic signed [TW_W-1:0]   w_wr, w_wi;

    assign w_br = b_i[2*DATA_W-1:DATA_W];
    assign w_bi = b_i[DATA_W-1:0];
    assign w_wr = w_i[2*TW_W-1:TW_W];
    assign w_wi = w_i[TW_W-1:0];

    logic signed [PW-1:0] prod_rr_q, prod_ii_q, prod_ri_q, prod_ir_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            prod_rr_q <= PW'(w_br) * PW'(w_wr);
            prod_ii_q <= PW'(w_bi) * PW'(w_wi);
            prod_ri_q <= PW'(w_br) * PW'(w_wi);
            prod_ir_q <= PW'(w_bi) * PW'(w_wr);
        end
    end

    logic signed [PW:0] w_re_sum, w_im_sum, w_re_rnd, w_im_rnd;

    // One guard bit keeps the -32768*-32768 corner exact before rounding.
    assign w_re_sum = (PW+1)'(prod_rr_q) - (PW+1)'(prod_ii_q);
    assign w_im_sum = (PW+1)'(prod_ri_q) + (PW+1)'(prod_ir_q);
    assign w_re_rnd = (w_re_sum + c_RND) >>> TW_FRAC;
    assign w_im_rnd = (w_im_sum + c_RND) >>> TW_FRAC;

    logic [DATA_W-1:0] wb_re_q, wb_im_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            wb_re_q <= sat16(w_re_rnd);
            wb_im_q <= sat16(w_im_rnd);
        end
    end

    assign wb_o = {wb_re_q, wb_im_q};

endmodule
`default_nettype wire

// File: rtl/fft_butterfly_r2.sv
`default_nettype none
// ============================================================================
// Module      : fft_butterfly_r2
// Description : Pipelined radix-2 DIT butterfly X=A+WB, Y=A-WB with optional
//               halving, saturation and full valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_butterfly_r2
    import fft_params_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TW_W    = COEFF_WIDTH,
    parameter int TW_FRAC = COEFF_FRAC
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [2*DATA_W-1:0]   s_a,
    input  logic [2*DATA_W-1:0]   s_b,
    input  logic [2:0]            s_stage,
    input  logic [7:0]            s_tw_idx,
    input  logic                  s_scale,
    input  logic [7:0]            s_tag,
    output logic [2:0]            tw_stage_idx,
    output logic [7:0]            tw_addr,
    input  logic [2*TW_W-1:0]     tw_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*DATA_W-1:0]   m_x,
    output logic [2*DATA_W-1:0]   m_y,
    output logic [7:0]            m_tag
);

    logic w_en;
    logic m_valid_q;

    assign w_en    = !m_valid_q || m_ready;
    assign s_ready = w_en && !rst;

    // While stalled the ROM re-reads the P1 twiddle so tw_data stays aligned.
    logic [7:0] p1_idx_q;
    logic [2:0] p1_stage_q;

    assign tw_addr      = w_en ? s_tw_idx : p1_idx_q;
    assign tw_stage_idx = w_en ? s_stage  : p1_stage_q;

    logic                p1_valid_q, p2_valid_q, p3_valid_q;
    logic [2*DATA_W-1:0] p1_a_q, p1_b_q, p2_a_q, p3_a_q;
    logic                p1_scale_q, p2_scale_q, p3_scale_q;
    logic [7:0]          p1_tag_q, p2_tag_q, p3_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_q <= 1'b0;
            p2_valid_q <= 1'b0;
            p3_valid_q <= 1'b0;
        end else if (w_en) begin
            p1_valid_q <= s_valid;
            p2_valid_q <= p1_valid_q;
            p3_valid_q <= p2_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            p1_a_q     <= s_a;
            p1_b_q     <= s_b;
            p1_idx_q   <= s_tw_idx;
            p1_stage_q <= s_stage;
            p1_scale_q <= s_scale;
            p1_tag_q   <= s_tag;
            p2_a_q     <= p1_a_q;
            p2_scale_q <= p1_scale_q;
            p2_tag_q   <= p1_tag_q;
            p3_a_q     <= p2_a_q;
            p3_scale_q <= p2_scale_q;
            p3_tag_q   <= p2_tag_q;
        end
    end

    logic [2*DATA_W-1:0] w_wb;

    fft_cmul #(
        .DATA_W  (DATA_W),
        .TW_W    (TW_W),
        .TW_FRAC (TW_FRAC)
    ) u_cmul (
        .clk  (clk),
        .en_i (w_en),
        .b_i  (p1_b_q),
        .w_i  (tw_data),
        .wb_o (w_wb)
    );

    function automatic logic [DATA_W-1:0] fin(input logic signed [DATA_W:0] v,
                                              input logic sc);
        logic signed [DATA_W+1:0] t;
        t = (DATA_W+2)'(v) + (DATA_W+2)'(1);
        if (sc) begin
            return t[DATA_W:1];
        end else begin
            return sat16(33'(v));
        end
    endfunction

    logic signed [DATA_W-1:0] w_ar, w_ai, w_wbr, w_wbi;
    logic signed [DATA_W:0]   w_xr, w_xi, w_yr, w_yi;
    logic [2*DATA_W-1:0]      m_x_d, m_y_d;

    assign w_ar  = p3_a_q[2*DATA_W-1:DATA_W];
    assign w_ai  = p3_a_q[DATA_W-1:0];
    assign w_wbr = w_wb[2*DATA_W-1:DATA_W];
    assign w_wbi = w_wb[DATA_W-1:0];

    assign w_xr = (DATA_W+1)'(w_ar) + (DATA_W+1)'(w_wbr);
    assign w_xi = (DATA_W+1)'(w_ai) + (DATA_W+1)'(w_wbi);
    assign w_yr = (DATA_W+1)'(w_ar) - (DATA_W+1)'(w_wbr);
    assign w_yi = (DATA_W+1)'(w_ai) - (DATA_W+1)'(w_wbi);

    assign m_x_d = {fin(w_xr, p3_scale_q), fin(w_xi, p3_scale_q)};
    assign m_y_d = {fin(w_yr, p3_scale_q), fin(w_yi, p3_scale_q)};

    logic [2*DATA_W-1:0] m_x_q, m_y_q;
    logic [7:0]          m_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_x_q     <= '0;
            m_y_q     <= '0;
            m_tag_q   <= '0;
        end else if (w_en) begin
            m_valid_q <= p3_valid_q;
            if (p3_valid_q) begin
                m_x_q   <= m_x_d;
                m_y_q   <= m_y_d;
                m_tag_q <= p3_tag_q;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_x     = m_x_q;
    assign m_y     = m_y_q;
    assign m_tag   = m_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_butterfly_r2.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_butterfly_r2
// Description : Directed and randomized bench for fft_butterfly_r2 with a
//               1-cycle twiddle ROM model and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_butterfly_r2;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, s_scale, m_valid, m_ready;
    logic [31:0] s_a, s_b, tw_data, m_x, m_y;
    logic [2:0]  s_stage, tw_stage_idx;
    logic [7:0]  s_tw_idx, s_tag, tw_addr, m_tag;

    always #5 clk = ~clk;

    fft_butterfly_r2 dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .s_stage      (s_stage),
        .s_tw_idx     (s_tw_idx),
        .s_scale      (s_scale),
        .s_tag        (s_tag),
        .tw_stage_idx (tw_stage_idx),
        .tw_addr      (tw_addr),
        .tw_data      (tw_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_x          (m_x),
        .m_y          (m_y),
        .m_tag        (m_tag)
    );

    logic [31:0] rom [256];
    always @(posedge clk) tw_data <= rom[tw_addr];

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0, n_err = 0, cyc = 0, n_out = 0;
    logic [7:0]  p1_idx_m = 8'h00;
    logic        stall_prev = 1'b0, after_rst = 1'b0, acc_last = 1'b0, check_lat = 1'b0;
    logic        dir_use = 1'b0;
    logic [31:0] dir_x, dir_y, hold_x, hold_y;
    logic [7:0]  hold_tag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint fin(input longint v, input logic sc);
        if (sc) return (v + 1) >>> 1;
        return sat(v);
    endfunction

    // X = A + W*B, Y = A - W*B in plain integer arithmetic.
    function automatic logic [63:0] ref_bf(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] w, input logic sc);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        logic [15:0] xr, xi, yr, yi;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        wr = longint'($signed(w[31:16]));
        wi = longint'($signed(w[15:0]));
        pr = sat((br * wr - bi * wi + 8192) >>> 14);
        pi = sat((br * wi + bi * wr + 8192) >>> 14);
        xr = 16'(fin(ar + pr, sc));
        xi = 16'(fin(ai + pi, sc));
        yr = 16'(fin(ar - pr, sc));
        yi = 16'(fin(ai - pi, sc));
        return {xr, xi, yr, yi};
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] idx, input logic sc, input logic [7:0] tag,
                        input logic mr, input logic r);
        exp_t        e;
        logic [63:0] res;
        @(negedge clk);
        if (after_rst) begin
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_m_x", 64'(m_x), 64'd0);
            chk("rst_m_y", 64'(m_y), 64'd0);
            chk("rst_m_tag", 64'(m_tag), 64'd0);
            after_rst = 1'b0;
        end
        if (stall_prev) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_x", 64'(m_x), 64'(hold_x));
            chk("hold_y", 64'(m_y), 64'(hold_y));
            chk("hold_tag", 64'(m_tag), 64'(hold_tag));
        end
        rst      = r;
        s_valid  = v;
        s_a      = a;
        s_b      = b;
        s_tw_idx = idx;
        s_stage  = idx[2:0];
        s_scale  = sc;
        s_tag    = tag;
        m_ready  = mr;
        #1;
        acc_last   = 1'b0;
        stall_prev = 1'b0;
        if (r) begin
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            q.delete();
            after_rst = 1'b1;
        end else begin
            if (m_valid && m_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_x", 64'(m_x), 64'(e.x));
                    chk("out_y", 64'(m_y), 64'(e.y));
                    chk("out_tag", 64'(m_tag), 64'(e.tag));
                    if (check_lat) chk("latency", 64'(cyc - e.cyc), 64'd4);
                end
            end
            if (m_valid && !m_ready) begin
                chk("stall_tw_addr", 64'(tw_addr), 64'(p1_idx_m));
                stall_prev = 1'b1;
                hold_x     = m_x;
                hold_y     = m_y;
                hold_tag   = m_tag;
            end
            if (s_valid && s_ready) begin
                acc_last = 1'b1;
                res      = ref_bf(a, b, rom[idx], sc);
                e.x      = dir_use ? dir_x : res[63:32];
                e.y      = dir_use ? dir_y : res[31:0];
                e.tag    = tag;
                e.cyc    = cyc;
                q.push_back(e);
            end
            if (!m_valid || m_ready) p1_idx_m = idx;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] idx,
                        input logic [31:0] w, input logic sc, input logic [7:0] tag,
                        input logic [31:0] ex, input logic [31:0] ey);
        rom[idx] = w;
        dir_use  = 1'b1;
        dir_x    = ex;
        dir_y    = ey;
        step(1'b1, a, b, idx, sc, tag, 1'b1, 1'b0);
        dir_use  = 1'b0;
    endtask

    initial begin
        int k, j, n0;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_stage = '0;
        s_tw_idx = '0; s_scale = 1'b0; s_tag = '0; m_ready = 1'b1;

        step(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);

        // Directed vectors, issued back to back at full throughput.
        check_lat = 1'b1;
        send(32'h03E8_0000, 32'h07D0_0000, 8'd1, 32'h4000_0000, 1'b0, 8'h11,
             32'h0BB8_0000, 32'hFC18_0000);
        send(32'h0000_0000, 32'h07D0_01F4, 8'd2, 32'h0000_C000, 1'b0, 8'h12,
             32'h01F4_F830, 32'hFE0C_07D0);
        send(32'h0000_0000, 32'h0001_0000, 8'd3, 32'h2000_0000, 1'b0, 8'h13,
             32'h0001_0000, 32'hFFFF_0000);
        send(32'h7FFF_0000, 32'h7FFF_0000, 8'd4, 32'h4000_0000, 1'b0, 8'h14,
             32'h7FFF_0000, 32'h0000_0000);
        send(32'h7FFF_0000, 32'h7FFF_0000, 8'd5, 32'h4000_0000, 1'b1, 8'h15,
             32'h7FFF_0000, 32'h0000_0000);
        send(32'h8000_0000, 32'h7FFF_0000, 8'd6, 32'h4000_0000, 1'b0, 8'h16,
             32'hFFFF_0000, 32'h8000_0000);
        idle(6);
        chk("directed_drained", 64'(q.size()), 64'd0);

        // Backpressure: m_ready follows 1,0,0,1,0,0,...
        check_lat = 1'b0;
        k  = 0;
        j  = 0;
        n0 = n_out;
        for (int i = 0; i < 200 && k < 8; i++) begin
            step(1'b1, $urandom, $urandom, 8'h40 + 8'(k), 1'($urandom_range(0, 1)),
                 8'h80 + 8'(k), (j % 3) == 0, 1'b0);
            j++;
            if (acc_last) k++;
        end
        chk("bp_all_sent", 64'(k), 64'd8);
        for (int i = 0; i < 60 && q.size() != 0; i++) begin
            step(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 8'd0, (j % 3) == 0, 1'b0);
            j++;
        end
        chk("bp_drained", 64'(q.size()), 64'd0);
        chk("bp_out_count", 64'(n_out - n0), 64'd8);
        idle(1);

        // Reset with three pairs in flight.
        check_lat = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, $urandom, 8'h20 + 8'(i), 1'b0, 8'h30 + 8'(i), 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b1, $urandom, $urandom, 8'h77, 1'b1, 8'hA5, 1'b1, 1'b0);
        idle(6);
        chk("post_rst_drained", 64'(q.size()), 64'd0);

        // Randomized traffic with random backpressure and bubbles.
        check_lat = 1'b0;
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 8'($urandom),
                 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
        for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
